// File: rtl/data_mem_lsu.sv
// data_mem_lsu: RV32 data memory with load/store formatting.
//   Accepts one request per cycle with no backpressure. Stores are committed at
//   the accepting edge. Loads are formatted (shift + sign/zero extension) and
//   returned in order after READ_LATENCY cycles (1 or 2).
// Ports:
//   Clk_Core, Rst_N            clock, asynchronous active-low reset
//   Req_Valid/Write/Funct3     request strobe, store flag, RV32 funct3
//   Req_Addr, Req_Wdata        byte address, right-justified store data
//   Rsp_Valid/Write            one-cycle response strobe, store echo
//   Rsp_Data                   formatted load data (0 for stores and errors)
//   Rsp_Err                    {illegal funct3, out of range, misaligned}
module data_mem_lsu #(
  parameter int unsigned MEM_SIZE     = 16384,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        Clk_Core,
  input  logic        Rst_N,
  input  logic        Req_Valid,
  input  logic        Req_Write,
  input  logic [2:0]  Req_Funct3,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_Wdata,
  output logic        Rsp_Valid,
  output logic        Rsp_Write,
  output logic [31:0] Rsp_Data,
  output logic [2:0]  Rsp_Err
);

  localparam int unsigned IDX_W     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_SIZE) << 2;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [2:0]  err;
    logic [31:0] word;
  } stage_t;

  logic [31:0]      mem_q [MEM_SIZE];
  logic [1:0]       off_c;
  logic [IDX_W-1:0] idx_c;
  logic             oor_c;
  logic             ill_c;
  logic             half_c;
  logic             word_c;
  logic             mis_c;
  logic [2:0]       err_c;
  logic             we_c;
  logic [3:0]       be_c;
  logic [31:0]      wd_c;
  stage_t           req_c;
  stage_t           fmt_c;

  logic        rsp_valid_d, rsp_valid_q;
  logic        rsp_write_d, rsp_write_q;
  logic [31:0] rsp_data_d,  rsp_data_q;
  logic [2:0]  rsp_err_d,   rsp_err_q;

  // Shift the addressed lane down and extend according to funct3.
  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (f3)
      3'd0:    res = {{24{sh[7]}}, sh[7:0]};
      3'd1:    res = {{16{sh[15]}}, sh[15:0]};
      3'd4:    res = {24'h0, sh[7:0]};
      3'd5:    res = {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Request decode: index, error classification and store lane generation.
  always_comb begin
    off_c  = Req_Addr[1:0];
    idx_c  = IDX_W'((Req_Addr - BASE_ADDR) >> 2);
    // 33-bit compare so a memory ending at the top of the address space cannot wrap.
    oor_c  = (Req_Addr < BASE_ADDR) ||
             ({1'b0, Req_Addr} >= ({1'b0, BASE_ADDR} + MEM_BYTES));
    ill_c  = Req_Write ? (Req_Funct3 > 3'd2)
                       : ((Req_Funct3 == 3'd3) || (Req_Funct3 == 3'd6) ||
                          (Req_Funct3 == 3'd7));
    // Size only means something for a legal funct3 (1/5 half, 2 word).
    half_c = !ill_c && (Req_Funct3[1:0] == 2'b01);
    word_c = !ill_c && (Req_Funct3[1:0] == 2'b10);
    mis_c  = (half_c && off_c[0]) || (word_c && (off_c != 2'b00));
    err_c  = {ill_c, oor_c, mis_c};

    // Writes are suppressed while reset is held so an edge during reset cannot land one.
    we_c = Req_Valid && Req_Write && (err_c == 3'b000) && Rst_N;
    case (Req_Funct3[1:0])
      2'b00: begin
        be_c = 4'b0001 << off_c;
        wd_c = {4{Req_Wdata[7:0]}};
      end
      2'b01: begin
        be_c = 4'b0011 << off_c;
        wd_c = {2{Req_Wdata[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = Req_Wdata;
      end
    endcase

    req_c.valid  = Req_Valid;
    req_c.write  = Req_Write;
    req_c.funct3 = Req_Funct3;
    req_c.off    = off_c;
    req_c.err    = err_c;
    req_c.word   = mem_q[idx_c];
  end

  // Word-wide RAM with byte-lane write enables; contents are not reset.
  always_ff @(posedge Clk_Core) begin
    if (we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) begin
          mem_q[idx_c][8*b +: 8] <= wd_c[8*b +: 8];
        end
      end
    end
  end

  // Optional RAM output register stage for the two-cycle configuration.
  if (READ_LATENCY == 2) begin : g_ram_reg
    stage_t s1_d, s1_q;

    always_comb begin
      s1_d = req_c;
    end

    always_ff @(posedge Clk_Core or negedge Rst_N) begin
      if (!Rst_N) begin
        s1_q <= '0;
      end else begin
        s1_q <= s1_d;
      end
    end

    assign fmt_c = s1_q;
  end else begin : g_no_reg
    assign fmt_c = req_c;
  end

  // Final stage: formatting; response fields hold between strobes.
  always_comb begin
    rsp_valid_d = fmt_c.valid;
    rsp_write_d = rsp_write_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (fmt_c.valid) begin
      rsp_write_d = fmt_c.write;
      rsp_err_d   = fmt_c.err;
      rsp_data_d  = (fmt_c.write || (fmt_c.err != 3'b000))
                    ? 32'h0 : fmt_load(fmt_c.funct3, fmt_c.off, fmt_c.word);
    end
  end

  always_ff @(posedge Clk_Core or negedge Rst_N) begin
    if (!Rst_N) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 3'b000;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign Rsp_Valid = rsp_valid_q;
  assign Rsp_Write = rsp_write_q;
  assign Rsp_Data  = rsp_data_q;
  assign Rsp_Err   = rsp_err_q;

endmodule
